mac: RTL and testbench
======================

Name: mac

Overview:
- Sequential signed fixed-point multiply-accumulate unit for the neural-net datapath.
- Consumes one (x, w) pair per clock for N consecutive cycles, starting on the cycle `start` is high.
- Produces the Q8.8 dot product on `acc` and flags completion on `done`.
- Serves as the inner-product engine under a layer/neuron controller that streams activations and weights.

Parameters:
- N, 4, number of products per dot product (N >= 1).
- DATA_W, 16, width of x, w and acc (signed Q8.8: 8 integer bits incl. sign, 8 fraction bits).
- FRAC, 8, number of fraction bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new dot product; the x/w pair sampled in this cycle is element 0.
- x  in  DATA_W  signed Q8.8 activation.
- w  in  DATA_W  signed Q8.8 weight.
- acc  out  DATA_W  signed Q8.8 accumulated result, saturated.
- done  out  1  result complete; held until next start.

Behaviour:
- Reset (rst_n low, async): internal accumulator=0, count=0, state=IDLE, acc=0, done=0.
- Arithmetic:
  - Product p = x*w as full 2*DATA_W signed (Q16.16).
  - Summed at full precision into an internal signed accumulator of 2*DATA_W+clog2(N)+1 bits; no intermediate rounding or overflow.
  - Output acc = internal sum arithmetic-shifted right by FRAC (truncation toward -inf), then saturated to [0x7FFF, 0x8000].
  - acc is a pure function of the accumulator register, so it shows running partial sums during a run.
- State IDLE:
  - Inputs are ignored unless start=1; accumulator and done hold.
  - start=1 at an edge: accumulator <= p (previous result discarded), count <= 1, done <= 0, state <= RUN.
  - Exception: if N==1, done <= 1 and state stays IDLE.
- State RUN:
  - Each edge: accumulator <= accumulator + p, count <= count+1.
  - On the edge that adds element N-1: done <= 1, state <= IDLE.
- Latency: start sampled at edge k means elements are sampled at edges k..k+N-1. done and the final acc are valid after edge k+N-1 and held indefinitely; later x/w changes do not alter them.
- start=1 during RUN: abort the current run and restart exactly as from IDLE. The new pair is element 0, done stays 0.
- start=1 in the same cycle done goes/is high: the restart wins, and done drops at that edge.
- Reset mid-run: immediate clear to the reset state; no partial result is retained.
- No backpressure and no valid qualifier: the producer must supply one pair per cycle after start.

Decomposition:
- Shared package:
  - Q8.8 constants DATA_W=16, FRAC=8, Q_ONE=16'sh0100, Q_MAX=16'sh7FFF, Q_MIN=16'sh8000.
  - Signed q8_t typedef.
  - Helper function for the saturating narrow (wide -> q8_t).
- One sub-module, mac_sat_narrow: combinational arithmetic shift by FRAC plus saturation from accumulator width to DATA_W.
- Multiplier and FSM stay in mac.

Test Plan:
- x=[1.0,2.0,3.0,4.0] (0x0100..0x0400), w=0.5 (0x0080) x4, start on first pair -> after 4th edge acc=0x0500 (5.0), done=1; two further cycles with x held at 4.0 -> acc still 0x0500, done still 1.
- Back-to-back restart: start with x=[1,-1,2,-2], w=1.0 x4 -> done drops on the start edge, final acc=0x0000, done=1.
- Saturation: x=127.0 (0x7F00), w=1.0 x4 -> acc=0x7FFF. x=-128.0 (0x8000), w=1.0 x4 -> acc=0x8000.
- Precision/truncation: x=0x0001, w=0x0001 x4 -> acc=0x0000. x=0x0001, w=0xFFFF (-1 lsb) x4 -> acc=0xFFFF (truncation toward -inf).
- Abort: start, 2 pairs of (1.0,1.0), then start again with 4 pairs of (0.5,1.0) -> acc=0x0200, done high only after the 4th pair of the second run.
- Async reset: assert rst_n=0 mid-run between edges -> acc=0, done=0 immediately. After release with no start, acc/done stay 0 regardless of x/w.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared Q8.8 fixed-point types, constants and the saturating narrow
// used by the multiply-accumulate datapath.
package mac_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC   = 8;

    typedef logic signed [DATA_W-1:0] q8_t;

    localparam q8_t Q_ONE = 16'sh0100;
    localparam q8_t Q_MAX = 16'sh7FFF;
    localparam q8_t Q_MIN = 16'sh8000;

    // Input is the full-precision sum sign-extended to 64 bits.
    function automatic q8_t sat_narrow(input logic signed [63:0] v);
        logic signed [63:0] s;
        q8_t                r;
        s = v >>> FRAC;
        if (s > 64'(Q_MAX)) begin
            r = Q_MAX;
        end else if (s < 64'(Q_MIN)) begin
            r = Q_MIN;
        end else begin
            r = q8_t'(s[DATA_W-1:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_sat_narrow.sv
// Combinational Q16.16 accumulator -> Q8.8 conversion: floor shift
// by FRAC followed by saturation to the q8_t range.
module mac_sat_narrow
    import mac_pkg::*;
#(
    parameter int ACC_W = 35
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output q8_t                     q_o
);

    logic signed [63:0] wide;

    always_comb begin
        wide = {{(64-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        q_o  = sat_narrow(wide);
    end

endmodule

// File: rtl/mac.sv
// Sequential signed Q8.8 multiply-accumulate: N products per dot
// product, full-precision accumulation, saturated Q8.8 result.
module mac
    import mac_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int FRAC   = mac_pkg::FRAC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [DATA_W-1:0] acc,
    output logic                     done
);

    localparam int P_W   = 2 * DATA_W;
    localparam int ACC_W = P_W + $clog2(N) + 1;
    localparam int CNT_W = $clog2(N + 1);

    // The narrowing helper is built around the package Q8.8 format.
    if (DATA_W != mac_pkg::DATA_W || FRAC != mac_pkg::FRAC) begin : g_chk
        $error("mac: DATA_W/FRAC must match mac_pkg");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;

    always_comb begin
        prod     = P_W'(x) * P_W'(w);
        prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (start) begin
            acc_d   = prod_ext;
            cnt_d   = CNT_W'(1);
            done_d  = (N == 1);
            state_d = (N == 1) ? IDLE : RUN;
        end else if (state_q == RUN) begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    q8_t acc_nar;

    mac_sat_narrow #(
        .ACC_W (ACC_W)
    ) u_sat (
        .acc_i (acc_q),
        .q_o   (acc_nar)
    );

    assign acc  = acc_nar;
    assign done = done_q;

endmodule

// File: tb/tb_mac.sv
// Scoreboard bench for mac: expected dot products are queued when a run
// is driven and compared when done rises.
module tb_mac;

    typedef logic [15:0] vec_t [4];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] w = '0;
    logic [15:0] acc;
    logic        done;

    int          n_checks = 0;
    int          n_err = 0;
    logic [15:0] sb_q [$];
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;

    mac #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .w     (w),
        .acc   (acc),
        .done  (done)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input vec_t xv, input vec_t wv);
        longint s = 0;
        longint q;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(xv[i])) * longint'($signed(wv[i]));
        end
        q = s >>> 8;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic tick();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 16'(done), 16'h0);
            end else begin
                e = sb_q.pop_front();
                check("sb_acc", acc, e);
            end
        end
        done_prev = done;
    endtask

    task automatic run(input vec_t xv, input vec_t wv, input int len,
                       input bit push);
        if (push) sb_q.push_back(model(xv, wv));
        for (int i = 0; i < len; i++) begin
            start = (i == 0);
            x = xv[i];
            w = wv[i];
            tick();
            if (i < 3) check($sformatf("busy_done%0d", i), 16'(done), 16'h0);
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t xv, wv;
        #2;
        check("rst_acc", acc, 16'h0000);
        check("rst_done", 16'(done), 16'h0);
        #10;
        rst_n = 1'b1;
        tick();
        check("idle_done", 16'(done), 16'h0);

        xv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        wv = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run(xv, wv, 4, 1);
        check("basic_done", 16'(done), 16'h1);
        check("basic_acc", acc, 16'h0500);
        tick();
        tick();
        check("hold_acc", acc, 16'h0500);
        check("hold_done", 16'(done), 16'h1);

        xv = '{16'h0100, 16'hFF00, 16'h0200, 16'hFE00};
        wv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run(xv, wv, 4, 1);
        check("b2b_acc", acc, 16'h0000);
        check("b2b_done", 16'(done), 16'h1);

        xv = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
        run(xv, wv, 4, 1);
        check("sat_pos", acc, 16'h7FFF);

        xv = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run(xv, wv, 4, 1);
        check("sat_neg", acc, 16'h8000);

        xv = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        run(xv, xv, 4, 1);
        check("trunc_pos", acc, 16'h0000);

        wv = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run(xv, wv, 4, 1);
        check("trunc_neg", acc, 16'hFFFF);

        xv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        wv = xv;
        run(xv, wv, 2, 0);
        xv = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run(xv, wv, 4, 1);
        check("abort_acc", acc, 16'h0200);
        check("abort_done", 16'(done), 16'h1);

        for (int t = 0; t < 4; t++) begin
            xv[t] = 16'($urandom);
            wv[t] = 16'($urandom);
        end
        run(xv, wv, 4, 1);
        check("rand_done", 16'(done), 16'h1);

        xv = '{16'h0300, 16'h0300, 16'h0300, 16'h0300};
        wv = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run(xv, wv, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_acc", acc, 16'h0000);
        check("arst_done", 16'(done), 16'h0);
        #10;
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            x = 16'($urandom);
            w = 16'($urandom);
            tick();
        end
        check("post_rst_acc", acc, 16'h0000);
        check("post_rst_done", 16'(done), 16'h0);
        check("sb_empty", 16'(sb_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
